adder_result_display: RTL and testbench
=======================================

# adder_result_display

Downstream consumer of the 4-bit adder: captures `{cout, sum}` on a valid strobe and presents the 5-bit result (0–31) in decimal on a two-digit multiplexed 7-segment display. Internally it holds a capture register, a binary-to-decimal split, a refresh prescaler and a digit-scan state. It sits between the adder outputs and the board display pins.

## Interface

- `REFRESH_DIV`, 50000: clock cycles each digit stays enabled. Legal range 2 to 2^20.
- `ACTIVE_LOW`, 1: when 1, `seg`, `dp` and `an` are active-low; when 0, active-high.
- `clk`: input, 1 bit, single clock. All state is updated on the rising edge.
- `rst`: input, 1 bit. Synchronous, active-high reset.
- `in_valid`: input, 1 bit. When high, `sum` and `cout` are captured at this edge.
- `sum`: input, 4 bits. Adder sum.
- `cout`: input, 1 bit. Adder carry-out.
- `seg`: output, 7 bits. Segments `{g,f,e,d,c,b,a}`. Registered.
- `dp`: output, 1 bit. Decimal point, used as the carry flag. Registered.
- `an`: output, 2 bits. Digit enables: `an[0]` is the ones digit, `an[1]` is the tens digit. One-hot. Registered.
- `value`: output, 5 bits. Captured `{cout, sum}`, for debug and verification.

## Operation

- **Capture.** When `in_valid=1`, `value <= {cout, sum}`. When `in_valid=0`, `value` holds; input changes are ignored.
- **Split.**
  - tens = `value / 10`, range 0–3. ones = `value % 10`.
  - Computed combinationally from `value` using compare/subtract. No divider.
- **Leading-zero blanking.** When tens = 0, the tens digit shows all segments off.
- **Prescaler.** `cnt` counts 0 to `REFRESH_DIV-1`. At terminal count it wraps to 0 and toggles `sel`.
- **Digit-scan state** `sel`, two states:
  - ONES: `an` enables digit 0; `seg` = encode(ones); `dp` off.
  - TENS: `an` enables digit 1; `seg` = encode(tens), or blank; `dp` lit when `value[4]=1`.
  - Transitions: ONES→TENS and TENS→ONES, each on prescaler terminal count only.
- **Encoding.** Active-high patterns for digits 0–9 are standard; `ACTIVE_LOW=1` inverts them.
  - Active-low examples: 0=`1000000`, 1=`1111001`, 2=`0100100`, 3=`0110000`, 5=`0010010`, 9=`0010000`.
  - Blank = `1111111`.
- **Reset values.**
  - `value=0`, `cnt=0`, `sel=ONES`.
  - `an=2'b10`, `seg=1000000`, `dp=1` (active-low case).
  - For `ACTIVE_LOW=0`, the active-high equivalents apply.

## Timing

- `value` updates at the edge where `in_valid` is sampled high (edge k).
- `seg`, `dp` and `an` reflect the new value from edge k+1 (one-cycle display latency).
- Scan: `an` changes at the edge following terminal count. Each digit is enabled for exactly `REFRESH_DIV` cycles. Full period is `2*REFRESH_DIV`.
- `in_valid` on the same edge as a digit toggle: both take effect. The new digit shows the new value one cycle later.
- Back-to-back `in_valid`: every cycle's value is captured; the last one wins.
- Reset mid-operation, in any state: at the reset edge all state returns to reset values. At the first edge with `rst=0`, counting resumes from `cnt=0`, `sel=ONES`.
- `rst` has priority over `in_valid`.
- `an` is never all-enabled or both-active, including during reset.

## Structure

- **Package `adder_display_pkg`** holds:
  - the `digit_sel_t` enum (`SEL_ONES`, `SEL_TENS`);
  - the active-high segment constants `SEG_0` … `SEG_9` and `SEG_BLANK`;
  - the `{g,f,e,d,c,b,a}` bit-order definition.
- **Sub-module `seg7_encoder`:** combinational, 4-bit digit plus blank input → 7-bit active-high pattern. Polarity inversion is applied in the parent at the output register.

## Test plan

Run with `REFRESH_DIV=4`.

- **Reset.** Assert `rst` for 2 cycles. Required: `an=10`, `seg=1000000`, `dp=1`, `value=0`. Then `an` toggles to `01` after exactly 4 cycles, and back to `10` 4 cycles later.
- **Single digit.** `sum=9`, `cout=0`, `in_valid` for 1 cycle. Required:
  - `value=9` at that edge;
  - ONES shows `0010000` from the next cycle;
  - TENS shows `1111111` with `dp=1`.
- **Carry.** `sum=4'hF`, `cout=1`, valid. Required: `value=31`; TENS shows `0110000` with `dp=0`; ONES shows `1111001` with `dp=1`.
- **Hold.** After capturing 25, sweep `sum` and `cout` every cycle with `in_valid=0` for 20 cycles. Required: `value` stays 25; TENS=`0100100`, ONES=`0010010` throughout.
- **Reset mid-scan.** Assert `rst` for 1 cycle at TENS with `cnt=2`. Required: next cycle `an=10`, `value=0`; the next toggle comes 4 cycles after `rst` deasserts.
- **Simultaneous events.** Pulse `in_valid` with value 12 on the terminal-count edge. Required: the display moves to the other digit and shows 12's digit (tens=`1111001`, ones=`0100100`) one cycle later, with no glitch to a stale value after that cycle.

Source files
------------

// File: rtl/adder_display_pkg.sv
// adder_display_pkg: shared types and active-high segment patterns for the adder result display
package adder_display_pkg;

    typedef enum logic {SEL_ONES = 1'b0, SEL_TENS = 1'b1} digit_sel_t;

    // Segment vectors are ordered {g,f,e,d,c,b,a}; bit 0 drives segment a
    typedef struct packed {
        logic g;
        logic f;
        logic e;
        logic d;
        logic c;
        logic b;
        logic a;
    } seg_t;

    localparam seg_t SEG_0     = 7'b0111111;
    localparam seg_t SEG_1     = 7'b0000110;
    localparam seg_t SEG_2     = 7'b1011011;
    localparam seg_t SEG_3     = 7'b1001111;
    localparam seg_t SEG_4     = 7'b1100110;
    localparam seg_t SEG_5     = 7'b1101101;
    localparam seg_t SEG_6     = 7'b1111101;
    localparam seg_t SEG_7     = 7'b0000111;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1101111;
    localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg7_encoder.sv
// seg7_encoder: decimal digit to active-high {g,f,e,d,c,b,a} pattern, with blanking
module seg7_encoder
    import adder_display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank)
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
    end

endmodule

// File: rtl/adder_result_display.sv
// adder_result_display: captures {cout,sum} and scans it as two decimal digits on a 7-segment display
module adder_result_display
    import adder_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter bit          ACTIVE_LOW  = 1'b1
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] sum,
    input  logic       cout,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] an,
    output logic [4:0] value
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [6:0] POL7 = {7{ACTIVE_LOW}};
    localparam logic [1:0] POL2 = {2{ACTIVE_LOW}};

    logic [CW-1:0] cnt;
    digit_sel_t    sel, sel_n;
    logic          tc, blank, dp_ah;
    logic [1:0]    tens, an_ah;
    logic [3:0]    ones, digit;
    logic [6:0]    pat;

    // Outputs are driven from the next scan state so an changes on the wrap edge itself
    always_comb begin
        tc    = cnt == CW'(REFRESH_DIV - 1);
        sel_n = tc ? (sel == SEL_ONES ? SEL_TENS : SEL_ONES) : sel;
        tens  = value >= 5'd30 ? 2'd3 : value >= 5'd20 ? 2'd2 : value >= 5'd10 ? 2'd1 : 2'd0;
        ones  = value >= 5'd30 ? 4'(value - 5'd30) :
                value >= 5'd20 ? 4'(value - 5'd20) :
                value >= 5'd10 ? 4'(value - 5'd10) : value[3:0];
        digit = sel_n == SEL_TENS ? {2'b00, tens} : ones;
        blank = sel_n == SEL_TENS && tens == 2'd0;
        an_ah = sel_n == SEL_TENS ? 2'b10 : 2'b01;
        dp_ah = sel_n == SEL_TENS && value[4];
    end

    seg7_encoder u_enc (
        .digit (digit),
        .blank (blank),
        .seg   (pat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
            cnt   <= '0;
            sel   <= SEL_ONES;
            seg   <= POL7 ^ SEG_0;
            an    <= POL2 ^ 2'b01;
            dp    <= ACTIVE_LOW;
        end else begin
            if (in_valid)
                value <= {cout, sum};
            cnt <= tc ? '0 : cnt + CW'(1);
            sel <= sel_n;
            seg <= POL7 ^ pat;
            an  <= POL2 ^ an_ah;
            dp  <= ACTIVE_LOW ^ dp_ah;
        end
    end

endmodule

// File: tb/tb_adder_result_display.sv
// tb_adder_result_display: directed checks of capture, decimal split, scan timing and reset
module tb_adder_result_display;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] sum = 4'd0;
    logic       cout = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] an;
    logic [4:0] value;
    int         checks = 0;
    int         errors = 0;

    adder_result_display #(.REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .sum      (sum),
        .cout     (cout),
        .seg      (seg),
        .dp       (dp),
        .an       (an),
        .value    (value)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        tick(2);
        chk("rst_an", 7'(an), 7'b0000010);
        chk("rst_seg", seg, 7'b1000000);
        chk("rst_dp", 7'(dp), 7'd1);
        chk("rst_value", 7'(value), 7'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("scan_an", 7'(an), (i >= 3 && i < 7) ? 7'b0000001 : 7'b0000010);
        end
        sum = 4'd9; cout = 1'b0; in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        chk("single_value", 7'(value), 7'd9);
        tick(1);
        chk("single_ones_seg", seg, 7'b0010000);
        chk("single_ones_dp", 7'(dp), 7'd1);
        chk("single_ones_an", 7'(an), 7'b0000010);
        tick(2);
        chk("single_tens_an", 7'(an), 7'b0000001);
        chk("single_tens_seg", seg, 7'b1111111);
        chk("single_tens_dp", 7'(dp), 7'd1);
        sum = 4'hF; cout = 1'b1; in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        chk("carry_value", 7'(value), 7'd31);
        chk("carry_stale_seg", seg, 7'b1111111);
        tick(1);
        chk("carry_tens_seg", seg, 7'b0110000);
        chk("carry_tens_dp", 7'(dp), 7'd0);
        chk("carry_tens_an", 7'(an), 7'b0000001);
        tick(2);
        chk("carry_ones_an", 7'(an), 7'b0000010);
        chk("carry_ones_seg", seg, 7'b1111001);
        chk("carry_ones_dp", 7'(dp), 7'd1);
        sum = 4'd9; cout = 1'b1; in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        chk("hold_capture", 7'(value), 7'd25);
        for (int i = 0; i < 20; i++) begin
            sum = 4'(i * 7);
            cout = i[0];
            tick(1);
            chk("hold_value", 7'(value), 7'd25);
            chk("hold_seg", seg, (((i + 2) / 4) % 2 == 1) ? 7'b0100100 : 7'b0010010);
            chk("hold_an", 7'(an), (((i + 2) / 4) % 2 == 1) ? 7'b0000001 : 7'b0000010);
        end
        tick(1);
        chk("mid_pre_an", 7'(an), 7'b0000001);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mid_rst_an", 7'(an), 7'b0000010);
        chk("mid_rst_value", 7'(value), 7'd0);
        chk("mid_rst_seg", seg, 7'b1000000);
        chk("mid_rst_dp", 7'(dp), 7'd1);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("mid_scan_an", 7'(an), i == 3 ? 7'b0000001 : 7'b0000010);
        end
        tick(3);
        sum = 4'd12; cout = 1'b0; in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        chk("sim_value", 7'(value), 7'd12);
        chk("sim_an", 7'(an), 7'b0000010);
        chk("sim_stale_seg", seg, 7'b1000000);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("sim_seg", seg, i >= 3 && i < 7 ? 7'b1111001 : 7'b0100100);
            chk("sim_an_scan", 7'(an), i >= 3 && i < 7 ? 7'b0000001 : 7'b0000010);
            chk("sim_dp", 7'(dp), 7'd1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
